sigmoid_lut_loader: RTL
=======================

// Module: sigmoid_lut_loader
// PURPOSE
//  Write-side counterpart of the sigmoid lookup table: a run-time programmable
//  1-port-write / 1-port-read LUT RAM. Entries arrive as a valid/ready stream and
//  are written at auto-incrementing addresses 0..DEPTH-1. Once the table is
//  full, the neuron activation stage reads it by address.
//  Replaces the fixed file-initialised table when coefficients are reloaded in-system.
// PARAMETERS
//  ADDR_W   10            address width; DEPTH = 2**ADDR_W entries
//  DATA_W   10            entry width (sigmoid output format)
//  CSUM_W   16            checksum width (used only with the checksum macro)
// PORTS
//  clock         in   1       single clock, rising edge
//  reset         in   1       asynchronous, active-low (0 = reset)
//  io_start      in   1       pulse: begin a full table load
//  io_in_valid   in   1       load stream data valid
//  io_in_ready   out  1       load stream ready
//  io_in_bits    in   DATA_W  load stream entry
//  io_busy       out  1       1 while in LOAD
//  io_done       out  1       1 while table is loaded (DONE state)
//  io_rd_en      in   1       read request
//  io_addr       in   ADDR_W  read address
//  io_dataOut    out  DATA_W  read data, registered
//  io_dataValid  out  1       read data valid, 1-cycle pulse per request
//  io_err        out  1       pulse: read requested while table not loaded
//  io_checksum   out  CSUM_W  running sum of loaded entries (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, io_in_ready=0, io_busy=0, io_done=0,
//   io_dataOut=0, io_dataValid=0, io_err=0, io_checksum=0. RAM not cleared.
//  FSM states: IDLE, LOAD, DONE.
//   IDLE: io_start=1 -> LOAD, wr_ptr<=0. Other inputs ignored.
//   LOAD: io_in_ready=1, io_busy=1. Fire = valid&ready: mem[wr_ptr]<=bits,
//    wr_ptr++. Fire with wr_ptr==DEPTH-1 -> DONE next cycle (wr_ptr wraps to 0).
//    io_start ignored in LOAD. Gaps in io_in_valid stall without penalty.
//   DONE: io_done=1, io_in_ready=0. io_start=1 -> LOAD, wr_ptr<=0, io_done=0
//    next cycle; previous contents kept until overwritten.
//  Reads: io_rd_en sampled at edge N; at edge N+1 (1-cycle latency)
//   io_dataValid=1 and io_dataOut=mem[io_addr] if state was DONE at edge N.
//   Otherwise io_dataValid=1, io_dataOut=0, io_err=1 for that cycle.
//   io_dataOut holds its last value when io_dataValid=0.
//  Simultaneous io_start and io_rd_en in DONE: read is serviced normally
//   (state is DONE at the sampling edge). The FSM moves to LOAD.
//  Write and read never collide: writes occur only in LOAD, and valid reads
//   occur only in DONE.
//  Reset asserted mid-load: immediate return to IDLE. A partial table is
//   discarded logically (io_done=0) and a full reload is required.
// CONFIGURATION
//  SIGMOID_LUT_CHECKSUM_EN defined: io_checksum cleared on LOAD entry and
//   incremented by zero-extended io_in_bits on every fire, mod 2**CSUM_W.
//   The value is stable in DONE.
//  Not defined: no accumulator logic; io_checksum tied to 0.
// TESTING
//  T1 start, stream 1024 words bits=addr[9:0], no gaps -> done after 1024 fires;
//     rd 0,511,1023 -> dataOut 0,511,1023 with dataValid one cycle later.
//  T2 same load with valid toggled every other cycle -> 1024 accepted,
//     no drop/dup; readback matches.
//  T3 rd_en at addr 5 during LOAD -> next cycle dataValid=1, err=1, dataOut=0;
//     load completes unaffected.
//  T4 in DONE, start+rd(addr 7) same cycle -> old mem[7] returned; busy=1;
//     reload bits=1023-addr; rd 7 -> 1016.
//  T5 reset low after 300 fires -> all outputs at reset values, ready=0;
//     start+full load -> normal done.
//  T6 (macro on) load all entries = 1 -> checksum=1024 in DONE;
//     (macro off) checksum=0 throughout.

Source files
------------

// File: rtl/sigmoid_lut_loader.sv
// Run-time loadable sigmoid LUT: valid/ready stream fills DEPTH entries, then reads are served by address.
// Optional SIGMOID_LUT_CHECKSUM_EN adds a running modular sum of the loaded entries on io_checksum.
module sigmoid_lut_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10,
    parameter int CSUM_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_bits,
    output logic              io_busy,
    output logic              io_done,
    input  logic              io_rd_en,
    input  logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_dataOut,
    output logic              io_dataValid,
    output logic              io_err,
    output logic [CSUM_W-1:0] io_checksum,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              fire;
    logic              load_entry;

    // Load stream handshake: an entry transfers on a rising edge where
    // io_in_valid and io_in_ready are both 1; ready is high only in LOAD and
    // the source must hold bits stable while valid is high and ready is low.
    assign io_in_ready = (state == S_LOAD);
    assign io_busy     = (state == S_LOAD);
    assign io_done     = (state == S_DONE);
    assign dbg_state   = state;
    assign fire        = io_in_valid && io_in_ready;
    assign load_entry  = io_start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io_start) begin
                        state  <= S_LOAD;
                        wr_ptr <= '0;
                    end
                end
                S_LOAD: begin
                    if (fire) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (wr_ptr == {ADDR_W{1'b1}}) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (io_start) begin
                        state  <= S_LOAD;
                        wr_ptr <= '0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wr_ptr <= '0;
                end
            endcase
        end
    end

    // Table storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (fire) begin
            mem[wr_ptr] <= io_in_bits;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_dataOut   <= '0;
            io_dataValid <= 1'b0;
            io_err       <= 1'b0;
        end else begin
            io_dataValid <= io_rd_en;
            io_err       <= io_rd_en && (state != S_DONE);
            if (io_rd_en) begin
                io_dataOut <= (state == S_DONE) ? mem[io_addr] : '0;
            end
        end
    end

`ifdef SIGMOID_LUT_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (load_entry) begin
            csum_q <= '0;
        end else if (fire) begin
            csum_q <= csum_q + CSUM_W'(io_in_bits);
        end
    end

    assign io_checksum = csum_q;
`else
    logic unused_load_entry;
    assign unused_load_entry = load_entry;
    assign io_checksum       = '0;
`endif

endmodule
